vif_chan_arbiter: RTL and testbench



---
 rtl/vif_chan_arbiter_if.sv | 30 +++
 rtl/vif_chan_arbiter.sv | 146 ++++++++++++++
 tb/tb_vif_chan_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/vif_chan_arbiter_if.sv
// Stream bundle for vif_chan_arbiter: NUM_CH writer channels in, one tagged stream out.
// The slave modport is the arbiter's view; master is the writers/reader side.
interface vif_chan_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  localparam int CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0]        s_valid;
  logic [NUM_CH-1:0]        s_ready;
  logic [NUM_CH*DATA_W-1:0] s_data;
  logic [NUM_CH*ADDR_W-1:0] s_addr;
  logic                     m_valid;
  logic                     m_ready;
  logic [DATA_W-1:0]        m_data;
  logic [ADDR_W-1:0]        m_addr;
  logic [CH_W-1:0]          m_ch;
  logic                     busy;

  modport master (
    output s_valid, s_data, s_addr, m_ready,
    input  s_ready, m_valid, m_data, m_addr, m_ch, busy
  );

  modport slave (
    input  s_valid, s_data, s_addr, m_ready,
    output s_ready, m_valid, m_data, m_addr, m_ch, busy
  );
endinterface

// File: rtl/vif_chan_arbiter.sv
// Per-channel DEPTH-entry FIFOs merged round-robin onto one channel-tagged stream.
// Optional grant counters / sticky stall flags: define VIF_CHAN_ARBITER_STATS_EN.
module vif_chan_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  vif_chan_arbiter_if.slave    bus
`ifdef VIF_CHAN_ARBITER_STATS_EN
  ,
  output logic [NUM_CH*16-1:0] grant_cnt,
  output logic [NUM_CH-1:0]    drop_stall
`endif
);
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  logic [NUM_CH-1:0]             w_ready;
  logic [NUM_CH-1:0]             w_push;
  logic [NUM_CH-1:0]             w_pop;
  logic [NUM_CH-1:0]             w_nonempty;
  logic [NUM_CH-1:0][BEAT_W-1:0] w_head;
  logic [CH_W-1:0]               r_rr_ptr;
  logic [CH_W-1:0]               r_lock_ch;
  logic                          r_lock_valid;
  logic [CH_W-1:0]               w_cand;
  logic [CH_W-1:0]               w_grant;
  logic                          w_any;
  logic                          w_accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_fifo
      logic [BEAT_W-1:0] r_mem [DEPTH];
      logic [PTR_W-1:0]  r_wr_ptr;
      logic [PTR_W-1:0]  r_rd_ptr;
      logic [CNT_W-1:0]  r_count;

      // Ready depends only on the stored count: a full FIFO refuses even when popping.
      assign w_ready[gi]    = (r_count != FULL_CNT);
      assign w_push[gi]     = bus.s_valid[gi] & w_ready[gi];
      assign w_pop[gi]      = w_accept & (w_grant == CH_W'(gi));
      assign w_nonempty[gi] = (r_count != '0);
      assign w_head[gi]     = r_mem[r_rd_ptr];

      always_ff @(posedge clk) begin
        if (w_push[gi]) begin
          r_mem[r_wr_ptr] <= {bus.s_addr[gi*ADDR_W +: ADDR_W], bus.s_data[gi*DATA_W +: DATA_W]};
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
        end else begin
          if (w_push[gi]) r_wr_ptr <= r_wr_ptr + 1'b1;
          if (w_pop[gi])  r_rd_ptr <= r_rd_ptr + 1'b1;
          case ({w_push[gi], w_pop[gi]})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
          endcase
        end
      end
    end
  endgenerate

  // First non-empty channel starting from the round-robin pointer.
  always_comb begin
    logic v_found;
    int   v_idx;
    v_found = 1'b0;
    v_idx   = 0;
    w_cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= NUM_CH) v_idx = v_idx - NUM_CH;
      if (!v_found && w_nonempty[CH_W'(v_idx)]) begin
        v_found = 1'b1;
        w_cand  = CH_W'(v_idx);
      end
    end
  end

  assign w_any    = |w_nonempty;
  assign w_grant  = r_lock_valid ? r_lock_ch : w_cand;
  assign w_accept = w_any & bus.m_ready;

  assign bus.s_ready = w_ready;
  assign bus.m_valid = w_any;
  assign bus.busy    = w_any;
  assign bus.m_ch    = w_any ? w_grant : '0;
  assign bus.m_data  = w_any ? w_head[w_grant][DATA_W-1:0] : '0;
  assign bus.m_addr  = w_any ? w_head[w_grant][BEAT_W-1:DATA_W] : '0;

  // A stalled grant is pinned so a newly filled closer channel cannot steal it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_lock_valid <= 1'b0;
      r_lock_ch    <= '0;
    end else begin
      if (w_accept) begin
        r_rr_ptr <= (w_grant == LAST_CH) ? '0 : w_grant + 1'b1;
      end
      if (w_any && !bus.m_ready) begin
        r_lock_valid <= 1'b1;
        r_lock_ch    <= w_grant;
      end else begin
        r_lock_valid <= 1'b0;
      end
    end
  end

`ifdef VIF_CHAN_ARBITER_STATS_EN
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_stats
      logic [15:0] r_grant_cnt;
      logic        r_drop;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_grant_cnt <= '0;
          r_drop      <= 1'b0;
        end else begin
          if (w_pop[gi] && (r_grant_cnt != 16'hFFFF)) r_grant_cnt <= r_grant_cnt + 1'b1;
          if (bus.s_valid[gi] && !w_ready[gi])        r_drop      <= 1'b1;
        end
      end

      assign grant_cnt[gi*16 +: 16] = r_grant_cnt;
      assign drop_stall[gi]         = r_drop;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_vif_chan_arbiter.sv
// Randomized + directed bench for vif_chan_arbiter; per-channel queue model with
// round-robin/grant-hold rules, checked by a negedge monitor on every cycle.
module tb_vif_chan_arbiter;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vif_chan_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef VIF_CHAN_ARBITER_STATS_EN
  logic [NUM_CH*16-1:0] grant_cnt;
  logic [NUM_CH-1:0]    drop_stall;
`endif

  vif_chan_arbiter #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef VIF_CHAN_ARBITER_STATS_EN
    ,
    .grant_cnt(grant_cnt),
    .drop_stall(drop_stall)
`endif
  );

  int    n_assert = 0;
  int    n_fail   = 0;
  bit    mon_en   = 1'b0;

  // Reference model state
  beat_t mq [NUM_CH][$];
  int    m_rr      = 0;
  bit    m_lock    = 1'b0;
  int    m_lock_ch = 0;
  int    m_gcnt [NUM_CH];
  bit    m_drop [NUM_CH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_grant();
    int idx;
    if (m_lock) return m_lock_ch;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (m_rr + k) % NUM_CH;
      if (mq[idx].size() > 0) return idx;
    end
    return -1;
  endfunction

  // Monitor: compare current outputs, then advance the model for the coming edge.
  always @(negedge clk) begin
    int g;
    logic [NUM_CH-1:0] rdy;
    g = exp_grant();
    for (int i = 0; i < NUM_CH; i++) rdy[i] = (mq[i].size() < DEPTH);

    if (mon_en) begin
      chk("m_valid", 32'(bus.m_valid), 32'(g >= 0));
      chk("busy",    32'(bus.busy),    32'(g >= 0));
      chk("s_ready", 32'(bus.s_ready), 32'(rdy));
      if (g >= 0) begin
        chk("m_ch",   32'(bus.m_ch),   32'(g));
        chk("m_data", 32'(bus.m_data), 32'(mq[g][0].d));
        chk("m_addr", 32'(bus.m_addr), 32'(mq[g][0].a));
      end else begin
        chk("m_ch_idle",   32'(bus.m_ch),   32'd0);
        chk("m_data_idle", 32'(bus.m_data), 32'd0);
        chk("m_addr_idle", 32'(bus.m_addr), 32'd0);
      end
`ifdef VIF_CHAN_ARBITER_STATS_EN
      for (int i = 0; i < NUM_CH; i++) begin
        chk($sformatf("grant_cnt[%0d]", i), 32'(grant_cnt[i*16 +: 16]), 32'(m_gcnt[i]));
        chk($sformatf("drop_stall[%0d]", i), 32'(drop_stall[i]), 32'(m_drop[i]));
      end
`endif
    end

    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mq[i].delete();
        m_gcnt[i] = 0;
        m_drop[i] = 1'b0;
      end
      m_rr   = 0;
      m_lock = 1'b0;
    end else begin
      if (g >= 0 && bus.m_ready) begin
        $display("beat ch=%0d addr=%02h data=%02h", g, mq[g][0].a, mq[g][0].d);
        void'(mq[g].pop_front());
        if (m_gcnt[g] < 16'hFFFF) m_gcnt[g]++;
        m_rr   = (g + 1) % NUM_CH;
        m_lock = 1'b0;
      end else if (g >= 0) begin
        m_lock    = 1'b1;
        m_lock_ch = g;
      end else begin
        m_lock = 1'b0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.s_valid[i] && rdy[i]) begin
          mq[i].push_back('{a: bus.s_addr[i*ADDR_W +: ADDR_W], d: bus.s_data[i*DATA_W +: DATA_W]});
        end
        if (bus.s_valid[i] && !rdy[i]) m_drop[i] = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int ch, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.s_valid[ch] = 1'b1;
    bus.s_addr[ch*ADDR_W +: ADDR_W] = a;
    bus.s_data[ch*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      m_gcnt[i] = 0;
      m_drop[i] = 1'b0;
    end
    bus.s_valid = '0;
    bus.s_data  = '0;
    bus.s_addr  = '0;
    bus.m_ready = 1'b0;
    rst         = 1'b1;
    tick();
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Single beat on channel 2, reader always ready
    bus.m_ready = 1'b1;
    set_beat(2, 8'h10, 8'hA5);
    tick();
    bus.s_valid = '0;
    repeat (3) tick();

    // Fill channel 0 while stalled, then a refused 5th beat, then drain
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      set_beat(0, 8'(i), 8'(i));
      tick();
    end
    bus.s_valid = '0;
    bus.m_ready = 1'b1;
    repeat (6) tick();

    // One beat on channel 3 moves the pointer to 0
    set_beat(3, 8'h33, 8'h33);
    tick();
    bus.s_valid = '0;
    repeat (2) tick();

    // Preload every channel, then release: expect 0,1,2,3
    bus.m_ready = 1'b0;
    for (int c = 0; c < NUM_CH; c++) set_beat(c, 8'(8'h20 + c), 8'(8'h40 + c));
    tick();
    bus.s_valid = '0;
    tick();
    bus.m_ready = 1'b1;
    repeat (6) tick();

    // Grant hold: channel 3 stalled while channel 1 arrives
    bus.m_ready = 1'b0;
    set_beat(3, 8'h03, 8'hC3);
    tick();
    bus.s_valid = '0;
    set_beat(1, 8'h01, 8'hC1);
    tick();
    bus.s_valid = '0;
    repeat (2) tick();
    bus.m_ready = 1'b1;
    repeat (4) tick();

    // Reset with beats buffered in channels 1 and 2
    bus.m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_beat(1, 8'(8'h50 + i), 8'(8'h60 + i));
      set_beat(2, 8'(8'h70 + i), 8'(8'h80 + i));
      tick();
    end
    bus.s_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.m_ready = 1'b1;
    repeat (3) tick();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      bus.s_valid = NUM_CH'($urandom);
      bus.s_data  = (NUM_CH*DATA_W)'($urandom);
      bus.s_addr  = (NUM_CH*ADDR_W)'($urandom);
      bus.m_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.s_valid = '0;
    bus.m_ready = 1'b1;
    repeat (NUM_CH*DEPTH + 4) tick();

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
